// File: rtl/test_monitor_pkg.sv
// test_monitor_pkg: shared FSM state type, tohost pass value and exit-code decode helper
//   used by test_monitor and its testbench-facing interface.
package test_monitor_pkg;
   typedef enum logic [2:0] {HOLD, RUN, PASS, FAIL, TMO} tm_state_e;
   localparam int TOHOST_PASS = 1;
   localparam int MAX_XLEN = 64;
   // odd tohost values carry the failure code in the upper bits
   function automatic logic [MAX_XLEN-1:0] exit_decode(input logic [MAX_XLEN-1:0] wdata);
      return wdata >> 1;
   endfunction
endpackage

// File: rtl/test_monitor_if.sv
// test_monitor_if: bundle between the monitored core/bus (master) and test_monitor (slave).
//   master drives mem_we/mem_addr/mem_wdata/instr_retire and observes core control,
//   done/pass/exit_code/timeout and the cycle/instret counters driven by the slave.
interface test_monitor_if #(
   parameter int XLEN = 32,
   parameter int CNT_W = 32
);
   logic             core_resetn;
   logic             core_run;
   logic             mem_we;
   logic [XLEN-1:0]  mem_addr;
   logic [XLEN-1:0]  mem_wdata;
   logic             instr_retire;
   logic             done;
   logic             pass;
   logic [XLEN-2:0]  exit_code;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instret;
   modport master (
      output mem_we, mem_addr, mem_wdata, instr_retire,
      input  core_resetn, core_run, done, pass, exit_code, timeout, cycle_count, instret
   );
   modport slave (
      input  mem_we, mem_addr, mem_wdata, instr_retire,
      output core_resetn, core_run, done, pass, exit_code, timeout, cycle_count, instret
   );
endinterface

// File: rtl/test_monitor_sat_counter.sv
// sat_counter: W-bit up counter with enable and synchronous clear that sticks at all-ones.
//   clk, resetn (async active-low), en_i (count), clr_i (clear, wins over en_i), q_o (count).
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         en_i,
   input  logic         clr_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] q_q, q_d;
   assign q_d = clr_i ? '0 : (en_i && q_q != '1) ? q_q + 1'b1 : q_q;
   assign q_o = q_q;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) q_q <= '0;
      else q_q <= q_d;
endmodule

// File: rtl/test_monitor.sv
// test_monitor: holds the core in reset, runs it, and ends the test on a tohost store or watchdog.
//   clk, resetn (async active-low); bus (test_monitor_if.slave): core_resetn/core_run out,
//   mem_we/mem_addr/mem_wdata/instr_retire in, done/pass/exit_code/timeout/cycle_count/instret out.
//   Define TEST_MONITOR_INSTRET_EN to count instr_retire pulses into instret (otherwise tied to 0).
module test_monitor
   import test_monitor_pkg::*;
#(
   parameter int              XLEN           = 32,
   parameter int              RESET_CYCLES   = 1,
   parameter int              TIMEOUT_CYCLES = 25,
   parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(32'h0000_0FFC),
   parameter int              CNT_W          = 32
) (
   input logic           clk,
   input logic           resetn,
   test_monitor_if.slave bus
);
   localparam int HW = $clog2(RESET_CYCLES + 1) + 1;
   tm_state_e        state_q;
   logic [HW-1:0]    hold_q;
   logic             core_resetn_q, core_run_q, done_q, pass_q, timeout_q;
   logic [XLEN-2:0]  exit_code_q, exit_d;
   logic [CNT_W-1:0] cycle_q, instret_q;
   logic             run, hit_d, pass_d, tmo_d;
   assign run    = state_q == RUN;
   // only odd values to tohost end the test; even ones are ignored
   assign hit_d  = run && bus.mem_we && bus.mem_addr == TOHOST_ADDR && bus.mem_wdata[0];
   assign pass_d = bus.mem_wdata == XLEN'(TOHOST_PASS);
   assign tmo_d  = run && cycle_q == CNT_W'(TIMEOUT_CYCLES - 1);
   assign exit_d = (XLEN-1)'(exit_decode(MAX_XLEN'(bus.mem_wdata)));
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state_q       <= HOLD;
         hold_q        <= '0;
         core_resetn_q <= 1'b0;
         core_run_q    <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         timeout_q     <= 1'b0;
         exit_code_q   <= '0;
      end else begin
         case (state_q)
            HOLD:
               if (hold_q == HW'(RESET_CYCLES - 1)) begin
                  state_q       <= RUN;
                  core_resetn_q <= 1'b1;
                  core_run_q    <= 1'b1;
               end else hold_q <= hold_q + 1'b1;
            RUN:
               // a tohost hit outranks a watchdog expiring on the same cycle
               if (hit_d) begin
                  state_q     <= pass_d ? PASS : FAIL;
                  core_run_q  <= 1'b0;
                  done_q      <= 1'b1;
                  pass_q      <= pass_d;
                  exit_code_q <= pass_d ? '0 : exit_d;
               end else if (tmo_d) begin
                  state_q    <= TMO;
                  core_run_q <= 1'b0;
                  done_q     <= 1'b1;
                  timeout_q  <= 1'b1;
               end
            default: ;
         endcase
      end
   sat_counter #(.W(CNT_W)) u_cycle (
      .clk    (clk),
      .resetn (resetn),
      .en_i   (run),
      .clr_i  (state_q == HOLD),
      .q_o    (cycle_q)
   );
`ifdef TEST_MONITOR_INSTRET_EN
   sat_counter #(.W(CNT_W)) u_instret (
      .clk    (clk),
      .resetn (resetn),
      .en_i   (run && bus.instr_retire),
      .clr_i  (state_q == HOLD),
      .q_o    (instret_q)
   );
`else
   assign instret_q = '0;
`endif
   assign bus.core_resetn = core_resetn_q;
   assign bus.core_run    = core_run_q;
   assign bus.done        = done_q;
   assign bus.pass        = pass_q;
   assign bus.timeout     = timeout_q;
   assign bus.exit_code   = exit_code_q;
   assign bus.cycle_count = cycle_q;
   assign bus.instret     = instret_q;
endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: directed and random tohost scenarios checked against a per-scenario outcome model.
module tb_test_monitor;
   localparam logic [31:0] TOHOST = 32'h0000_0FFC;
   localparam int TMO_C = 25;
   localparam int NCYC = 32;
   logic clk = 1'b0;
   logic resetn;
   int total = 0;
   int bad = 0;
   logic        p_we  [1:NCYC];
   logic [31:0] p_addr[1:NCYC];
   logic [31:0] p_wd  [1:NCYC];
   logic        p_ret [1:NCYC];
   test_monitor_if #(.XLEN(32), .CNT_W(32)) bus ();
   test_monitor #(
      .XLEN(32), .RESET_CYCLES(1), .TIMEOUT_CYCLES(TMO_C), .TOHOST_ADDR(TOHOST), .CNT_W(32)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.mem_we = 1'b0;
      bus.mem_addr = '0;
      bus.mem_wdata = '0;
      bus.instr_retire = 1'b0;
   endtask

   task automatic drive(input int k);
      bus.mem_we = p_we[k];
      bus.mem_addr = p_addr[k];
      bus.mem_wdata = p_wd[k];
      bus.instr_retire = p_ret[k];
   endtask

   task automatic clear_plan();
      for (int k = 1; k <= NCYC; k++) begin
         p_we[k] = 1'b0;
         p_addr[k] = '0;
         p_wd[k] = '0;
         p_ret[k] = 1'b0;
      end
   endtask

   task automatic store(input int k, input logic [31:0] a, input logic [31:0] w);
      p_we[k] = 1'b1;
      p_addr[k] = a;
      p_wd[k] = w;
   endtask

   task automatic check_cleared(input string tag);
      chk($sformatf("%s.core_resetn", tag), bus.core_resetn, 0);
      chk($sformatf("%s.core_run", tag), bus.core_run, 0);
      chk($sformatf("%s.done", tag), bus.done, 0);
      chk($sformatf("%s.pass", tag), bus.pass, 0);
      chk($sformatf("%s.timeout", tag), bus.timeout, 0);
      chk($sformatf("%s.exit_code", tag), bus.exit_code, 0);
      chk($sformatf("%s.cycle_count", tag), bus.cycle_count, 0);
      chk($sformatf("%s.instret", tag), bus.instret, 0);
   endtask

   // release reset on a falling edge with a qualifying store pending: HOLD must ignore it
   task automatic release_reset(input string tag);
      @(negedge clk);
      resetn = 1'b1;
      bus.mem_we = 1'b1;
      bus.mem_addr = TOHOST;
      bus.mem_wdata = 32'd1;
      bus.instr_retire = 1'b1;
      #1;
      chk($sformatf("%s.hold_resetn", tag), bus.core_resetn, 0);
      @(posedge clk);
      #1;
      chk($sformatf("%s.run_resetn", tag), bus.core_resetn, 1);
      chk($sformatf("%s.run_run", tag), bus.core_run, 1);
      chk($sformatf("%s.run_done", tag), bus.done, 0);
      chk($sformatf("%s.run_cycles", tag), bus.cycle_count, 0);
      chk($sformatf("%s.run_instret", tag), bus.instret, 0);
      idle();
   endtask

   task automatic reset_pulse(input string tag);
      @(negedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check_cleared(tag);
      release_reset(tag);
   endtask

   // outcome model: the first odd store to tohost within the watchdog window ends the test
   task automatic run_plan(input string tag);
      int n_end;
      logic hit;
      logic [31:0] w;
      int ret;
      n_end = TMO_C;
      hit = 1'b0;
      w = '0;
      ret = 0;
      for (int k = 1; k <= TMO_C && !hit; k++)
         if (p_we[k] && p_addr[k] == TOHOST && p_wd[k][0]) begin
            hit = 1'b1;
            n_end = k;
            w = p_wd[k];
         end
      for (int k = 1; k <= n_end; k++) ret += int'(p_ret[k]);
      for (int k = 1; k <= NCYC; k++) begin
         drive(k);
         @(posedge clk);
         #1;
         chk($sformatf("%s.done@%0d", tag, k), bus.done, 64'(k >= n_end));
         chk($sformatf("%s.core_run@%0d", tag, k), bus.core_run, 64'(k < n_end));
      end
      idle();
      chk($sformatf("%s.pass", tag), bus.pass, 64'(hit && w == 32'd1));
      chk($sformatf("%s.timeout", tag), bus.timeout, 64'(!hit));
      chk($sformatf("%s.exit_code", tag), bus.exit_code, (hit && w != 32'd1) ? 64'(w >> 1) : 64'd0);
      chk($sformatf("%s.cycle_count", tag), bus.cycle_count, 64'(n_end));
      chk($sformatf("%s.core_resetn", tag), bus.core_resetn, 1);
`ifdef TEST_MONITOR_INSTRET_EN
      chk($sformatf("%s.instret", tag), bus.instret, 64'(ret));
`else
      chk($sformatf("%s.instret", tag), bus.instret, 0);
`endif
   endtask

   task automatic plan_pass12();
      clear_plan();
      store(12, TOHOST, 32'd1);
      store(14, TOHOST, 32'd7);
      for (int k = 2; k <= 6; k++) p_ret[k] = 1'b1;
   endtask

   task automatic plan_random(input int we_odds);
      logic [31:0] r;
      clear_plan();
      for (int k = 1; k <= NCYC; k++) begin
         p_we[k] = $urandom_range(0, we_odds) == 0;
         p_addr[k] = ($urandom_range(0, 2) == 0) ? TOHOST : $urandom;
         r = $urandom;
         case ($urandom_range(0, 4))
            0: p_wd[k] = 32'd1;
            1, 2: p_wd[k] = {r[31:1], 1'b0};
            default: p_wd[k] = r | 32'd1;
         endcase
         p_ret[k] = $urandom_range(0, 1) == 1;
      end
   endtask

   initial begin
      resetn = 1'b0;
      idle();
      #2;
      check_cleared("por");
      release_reset("por");
      plan_pass12();
      run_plan("pass12");
      reset_pulse("r_fail");
      clear_plan();
      store(3, 32'h0000_0FF8, 32'd1);
      store(5, TOHOST, 32'd7);
      p_ret[1] = 1'b1;
      run_plan("fail7");
      reset_pulse("r_tmo");
      clear_plan();
      store(10, TOHOST, 32'd4);
      store(20, 32'h0000_1000, 32'd3);
      run_plan("tmo");
      reset_pulse("r_edge");
      clear_plan();
      store(25, TOHOST, 32'd1);
      run_plan("tmo_pass");
      reset_pulse("r_mid");
      plan_pass12();
      for (int k = 1; k <= 7; k++) begin
         drive(k);
         @(posedge clk);
         #1;
      end
      chk("mid.cycle_count", bus.cycle_count, 7);
      #2;
      resetn = 1'b0;
      #1;
      check_cleared("mid");
      release_reset("mid");
      run_plan("rerun");
      for (int i = 0; i < 8; i++) begin
         reset_pulse($sformatf("r_rnd%0d", i));
         plan_random((i % 2 == 0) ? 3 : 12);
         run_plan($sformatf("rnd%0d", i));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
